// File: rtl/router_pkg.sv
// Shared types and constants for the router read-side arbiter.
// Holds the FSM encoding and the round-robin port picker.
package router_pkg;

   localparam int unsigned NPORT      = 3;
   localparam int unsigned PKT_OVH    = 2;
   localparam int unsigned BUF_W      = 10;
   localparam logic [1:0]  GRANT_NONE = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StHwait,
      StBody
   } arb_state_e;

   // First requesting port strictly after `last`, wrapping; GRANT_NONE if nobody requests.
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [NPORT-1:0] req);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = GRANT_NONE;
      idx  = last;
      for (int unsigned k = 0; k < NPORT; k++) begin
         idx = (idx == 2'(NPORT - 1)) ? 2'd0 : idx + 2'd1;
         if ((pick == GRANT_NONE) && req[idx]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry FIFO carrying {sop, eop, data}; head is zeroed while empty.
// Overflow is prevented upstream by counting in-flight reads.
module router_skid_buf
   import router_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [BUF_W-1:0] push_data,
   input  logic             pop,
   output logic [BUF_W-1:0] head,
   output logic [1:0]       count
);

   logic [BUF_W-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             pop_ok;
   logic             push_ok;

   always_comb begin
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'd2) || pop_ok);
      head    = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
      count   = count_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/router_rd_arbiter.sv
// Round-robin read scheduler for the three router FIFOs; streams one whole
// packet at a time into a tagged valid/ready byte stream.
module router_rd_arbiter #(
   parameter int unsigned NPORT     = 3,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       vldout_0,
   input  logic       vldout_1,
   input  logic       vldout_2,
   input  logic [7:0] data_out_0,
   input  logic [7:0] data_out_1,
   input  logic [7:0] data_out_2,
   output logic       read_enb_0,
   output logic       read_enb_1,
   output logic       read_enb_2,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sop,
   output logic       out_eop,
   output logic [1:0] grant
);

   import router_pkg::*;

   arb_state_e       state_q;
   logic [1:0]       grant_q;
   logic [1:0]       rr_ptr_q;
   logic [6:0]       rd_cnt_q;
   logic [6:0]       tot_q;
   logic             pend_q;
   logic [1:0]       pend_port_q;
   logic             pend_sop_q;
   logic             pend_eop_q;

   logic [NPORT-1:0] vld;
   logic             vld_g;
   logic [BUF_W-1:0] head;
   logic [1:0]       count;
   logic             pop;
   logic             space;
   logic             issue;
   logic             eop_now;
   logic [7:0]       ret_byte;
   logic [6:0]       hdr_tot;

   always_comb begin
      vld = {vldout_2, vldout_1, vldout_0};
      case (grant_q)
         2'd0:    vld_g = vldout_0;
         2'd1:    vld_g = vldout_1;
         2'd2:    vld_g = vldout_2;
         default: vld_g = 1'b0;
      endcase
      case (pend_port_q)
         2'd0:    ret_byte = data_out_0;
         2'd1:    ret_byte = data_out_1;
         default: ret_byte = data_out_2;
      endcase
      pop = (count != 2'd0) && out_ready;
      // Bytes held plus the one returning this cycle, less the one leaving, must leave a slot.
      space   = ({1'b0, count} + {2'b00, pend_q}) < (3'(BUF_DEPTH) + {2'b00, pop});
      issue   = space && ((state_q == StHdr) || ((state_q == StBody) && vld_g));
      eop_now = (state_q == StBody) && (rd_cnt_q == tot_q - 7'd1);
      hdr_tot = 7'(ret_byte[7:2]) + 7'(PKT_OVH);
   end

   always_comb begin
      read_enb_0 = issue && (grant_q == 2'd0);
      read_enb_1 = issue && (grant_q == 2'd1);
      read_enb_2 = issue && (grant_q == 2'd2);
      out_valid  = (count != 2'd0);
      out_sop    = head[9];
      out_eop    = head[8];
      out_data   = head[7:0];
      grant      = grant_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         grant_q     <= GRANT_NONE;
         rr_ptr_q    <= 2'd2;
         rd_cnt_q    <= 7'd0;
         tot_q       <= 7'd0;
         pend_q      <= 1'b0;
         pend_port_q <= 2'd0;
         pend_sop_q  <= 1'b0;
         pend_eop_q  <= 1'b0;
      end else begin
         pend_q      <= issue;
         pend_port_q <= grant_q;
         pend_sop_q  <= (state_q == StHdr);
         pend_eop_q  <= eop_now;
         case (state_q)
            StIdle: begin
               if (|vld) begin
                  grant_q <= rr_pick(rr_ptr_q, vld);
                  state_q <= StHdr;
               end
            end
            StHdr: begin
               if (space) begin
                  rd_cnt_q <= 7'd1;
                  state_q  <= StHwait;
               end
            end
            StHwait: begin
               // The header read issued in StHdr is on the FIFO bus now.
               tot_q   <= hdr_tot;
               state_q <= StBody;
            end
            StBody: begin
               if (issue) begin
                  rd_cnt_q <= rd_cnt_q + 7'd1;
                  if (eop_now) begin
                     rr_ptr_q <= grant_q;
                     grant_q  <= GRANT_NONE;
                     state_q  <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   router_skid_buf u_buf (
      .clk       (clk),
      .resetn    (resetn),
      .push      (pend_q),
      .push_data ({pend_sop_q, pend_eop_q, ret_byte}),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_router_rd_arbiter.sv
// Bench for router_rd_arbiter: FIFO sources, packet-level round-robin model
// and an in-order byte scoreboard.
module tb_router_rd_arbiter;

   logic       clk = 1'b0;
   logic       resetn;
   logic       vldout_0, vldout_1, vldout_2;
   logic [7:0] data_out_0, data_out_1, data_out_2;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic [7:0] out_data;
   logic       out_valid, out_ready, out_sop, out_eop;
   logic [1:0] grant;

   always #5 clk = ~clk;

   router_rd_arbiter dut (
      .clk        (clk),
      .resetn     (resetn),
      .vldout_0   (vldout_0),
      .vldout_1   (vldout_1),
      .vldout_2   (vldout_2),
      .data_out_0 (data_out_0),
      .data_out_1 (data_out_1),
      .data_out_2 (data_out_2),
      .read_enb_0 (read_enb_0),
      .read_enb_1 (read_enb_1),
      .read_enb_2 (read_enb_2),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .grant      (grant)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] fifo_q [3][$];
   logic [7:0] mdl_bytes [3][$];
   int         pkt_len [3][$];
   logic [9:0] exp_q [$];
   bit         rdy_pat [$];
   bit         rdy_rand = 1'b0;
   int         hold [3];
   logic [7:0] nxt_data [3];
   int         reads_tot, acc_tot, first_port, last_port;
   int         port_reads [3];
   logic [2:0] s_ren, s_vld;
   logic [1:0] s_grant;
   logic       s_valid, s_sop, s_eop;
   logic [7:0] s_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int p = 0; p < 3; p++) begin
         fifo_q[p].delete();
         mdl_bytes[p].delete();
         pkt_len[p].delete();
         hold[p]       = 0;
         nxt_data[p]   = 8'h00;
         port_reads[p] = 0;
      end
      exp_q.delete();
      rdy_pat.delete();
      reads_tot  = 0;
      acc_tot    = 0;
      first_port = -1;
      last_port  = 2;
   endtask

   // One clock: drive inputs after the edge, sample mid-cycle, resolve pops and accepts.
   task automatic cycle();
      @(posedge clk);
      #1;
      data_out_0 = nxt_data[0];
      data_out_1 = nxt_data[1];
      data_out_2 = nxt_data[2];
      vldout_0 = (fifo_q[0].size() > 0) && (hold[0] == 0);
      vldout_1 = (fifo_q[1].size() > 0) && (hold[1] == 0);
      vldout_2 = (fifo_q[2].size() > 0) && (hold[2] == 0);
      for (int p = 0; p < 3; p++) if (hold[p] > 0) hold[p]--;
      if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
      else if (rdy_rand)      out_ready = 1'($urandom_range(0, 1));
      else                    out_ready = 1'b1;
      #3;
      s_ren   = {read_enb_2, read_enb_1, read_enb_0};
      s_vld   = {vldout_2, vldout_1, vldout_0};
      s_grant = grant;
      s_valid = out_valid;
      s_sop   = out_sop;
      s_eop   = out_eop;
      s_data  = out_data;
      chk("occupancy_le_2", 32'((reads_tot - acc_tot) <= 2), 32'd1);
      chk("ren_onehot0", 32'($countones(s_ren) <= 1), 32'd1);
      for (int p = 0; p < 3; p++) begin
         if (s_ren[p]) begin
            chk("ren_grant", 32'(s_grant), 32'(p));
            chk("ren_while_vld", 32'(s_vld[p]), 32'd1);
            chk("ren_nonempty", 32'(fifo_q[p].size() > 0), 32'd1);
            if (fifo_q[p].size() > 0) nxt_data[p] = fifo_q[p].pop_front();
            reads_tot++;
            port_reads[p]++;
            if (first_port < 0) first_port = p;
         end
      end
      if (s_valid && out_ready) begin
         chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("stream_byte", 32'({s_sop, s_eop, s_data}), 32'(exp_q.pop_front()));
         acc_tot++;
      end
   endtask

   task automatic load_pkt(input int p, input int len);
      logic [7:0] b, par;
      b   = {len[5:0], p[1:0]};
      par = b;
      fifo_q[p].push_back(b);
      mdl_bytes[p].push_back(b);
      for (int i = 0; i < len; i++) begin
         b   = 8'($urandom);
         par = par ^ b;
         fifo_q[p].push_back(b);
         mdl_bytes[p].push_back(b);
      end
      fifo_q[p].push_back(par);
      mdl_bytes[p].push_back(par);
      pkt_len[p].push_back(len);
   endtask

   // Whole packets leave in round-robin port order, starting after the last served port.
   task automatic schedule();
      bit found;
      do begin
         found = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            int p;
            p = (last_port + k) % 3;
            if (!found && pkt_len[p].size() > 0) begin
               int t;
               t = pkt_len[p].pop_front() + 2;
               for (int i = 0; i < t; i++) begin
                  logic [7:0] b;
                  b = mdl_bytes[p].pop_front();
                  exp_q.push_back({(i == 0), (i == t - 1), b});
               end
               last_port = p;
               found     = 1'b1;
            end
         end
      end while (found);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || fifo_q[0].size() > 0 || fifo_q[1].size() > 0 ||
              fifo_q[2].size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 32'd1);
      repeat (4) cycle();
   endtask

   initial begin
      int n;
      resetn = 1'b0;
      {vldout_0, vldout_1, vldout_2} = 3'b000;
      {data_out_0, data_out_1, data_out_2} = 24'h0;
      out_ready = 1'b1;
      clear_model();
      cycle();
      cycle();
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_data", 32'(s_data), 32'd0);
      chk("rst_sop", 32'(s_sop), 32'd0);
      chk("rst_eop", 32'(s_eop), 32'd0);
      chk("rst_grant", 32'(s_grant), 32'd3);
      chk("rst_ren", 32'(s_ren), 32'd0);
      resetn = 1'b1;
      cycle();

      // First-packet latency, L=0 header on port 0.
      load_pkt(0, 0);
      schedule();
      cycle();
      chk("c0_ren", 32'(s_ren), 32'd0);
      cycle();
      chk("c1_grant", 32'(s_grant), 32'd0);
      chk("c1_ren", 32'(s_ren), 32'b001);
      cycle();
      chk("c2_valid", 32'(s_valid), 32'd0);
      cycle();
      chk("c3_valid", 32'(s_valid), 32'd1);
      chk("c3_sop", 32'(s_sop), 32'd1);
      chk("c3_hdr", 32'(s_data), 32'h00);
      drain(200);
      chk("l0_reads", 32'(port_reads[0]), 32'd2);

      // Port 1, header 8'h0D.
      port_reads[1] = 0;
      load_pkt(1, 3);
      schedule();
      drain(200);
      chk("p1_reads", 32'(port_reads[1]), 32'd5);

      // All three ports at once after reset, then fresh data.
      resetn = 1'b0;
      clear_model();
      cycle();
      resetn = 1'b1;
      for (int p = 0; p < 3; p++) load_pkt(p, 1);
      schedule();
      drain(300);
      chk("rr_first_after_reset", 32'(first_port), 32'd0);
      first_port = -1;
      load_pkt(0, 1);
      load_pkt(2, 1);
      schedule();
      drain(300);
      chk("rr_wrap_to_0", 32'(first_port), 32'd0);

      // Backpressure during payload.
      load_pkt(2, 6);
      schedule();
      repeat (5) cycle();
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      drain(300);

      // Source stall mid-payload on port 2.
      load_pkt(2, 8);
      schedule();
      repeat (6) cycle();
      hold[2] = 4;
      repeat (4) begin
         cycle();
         chk("gap_grant", 32'(s_grant), 32'd2);
         chk("gap_no_read", 32'(s_ren), 32'd0);
      end
      drain(300);

      // Random bursts with random backpressure.
      rdy_rand = 1'b1;
      for (int b = 0; b < 6; b++) begin
         for (int p = 0; p < 3; p++) begin
            int np;
            np = int'($urandom_range(0, 2));
            for (int i = 0; i < np; i++) load_pkt(p, int'($urandom_range(0, 20)));
         end
         schedule();
         drain(3000);
      end
      rdy_rand = 1'b0;

      // Reset in the middle of a packet body.
      port_reads[1] = 0;
      load_pkt(1, 10);
      schedule();
      n = 0;
      while (port_reads[1] < 4 && n < 50) begin
         cycle();
         n++;
      end
      chk("midbody_reached", 32'(port_reads[1] >= 4), 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_ren", 32'({read_enb_2, read_enb_1, read_enb_0}), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_tags", 32'({out_sop, out_eop}), 32'd0);
      chk("mid_rst_grant", 32'(grant), 32'd3);
      clear_model();
      cycle();
      cycle();
      resetn = 1'b1;
      for (int p = 0; p < 3; p++) load_pkt(p, 2);
      schedule();
      drain(300);
      chk("post_rst_first", 32'(first_port), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
